spi_xfer_ctrl: RTL
==================

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving transfer word width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  transfer request, sampled only in IDLE.
REQ-005 SHALL have port tx_data  input  DATA_W  word to transmit, MSB first.
REQ-006 SHALL have port pres_clk  input  1  divided clock from the prescaler, synchronous to clk.
REQ-007 SHALL have port pres_en  output  1  prescaler enable; prescaler holds pres_clk=0 while low.
REQ-008 SHALL have port sclk  output  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0).
REQ-009 SHALL have port mosi  output  1  serial data out.
REQ-010 SHALL have port miso  input  1  serial data in.
REQ-011 SHALL have port cs_n  output  1  active-low chip select.
REQ-012 SHALL have port rx_data  output  DATA_W  last received word.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, SHIFT, HOLD, DONE.
REQ-016 SHALL register pres_clk into pres_d each cycle; rise = pres_clk & ~pres_d, fall = ~pres_clk & pres_d; pres_d forced 0 in IDLE.
REQ-017 IDLE: cs_n=1, pres_en=0, sclk=0, busy=0, done=0; mosi holds last value.
REQ-018 IDLE with start=1: load tx shift register with tx_data, mosi<=tx_data[DATA_W-1], cs_n<=0, pres_en<=1, bit counter<=0, go SHIFT next cycle.
REQ-019 start SHALL be ignored in SHIFT, HOLD and DONE (no restart, no data reload).
REQ-020 SHIFT: sclk SHALL be a registered copy of pres_clk (one clk delay), so mosi is stable at least half an SCLK period before each sclk rising edge.
REQ-021 SHIFT on rise: rx shift register <= {rx_shift[DATA_W-2:0], miso}; bit counter increments.
REQ-022 SHIFT on fall with bit counter < DATA_W: tx shift register shifts left by one; mosi <= new MSB.
REQ-023 SHIFT on fall with bit counter == DATA_W: pres_en<=0, go HOLD; mosi unchanged.
REQ-024 Bit counter width SHALL be clog2(DATA_W)+1 bits; no wrap within a transfer.
REQ-025 HOLD: one clk cycle with cs_n=0, sclk=0, pres_en=0; then go DONE.
REQ-026 DONE: cs_n<=1, rx_data<=rx shift register, done=1 for exactly this cycle, busy=1; go IDLE next cycle.
REQ-027 A transfer SHALL produce exactly DATA_W sclk rising edges and DATA_W sclk falling edges.
REQ-028 rx_data SHALL change only in DONE and on reset.
REQ-029 Simultaneous rise and fall in one cycle cannot occur; no special handling required.

Reset
REQ-030 rst low SHALL, asynchronously and at any state including mid-transfer: state=IDLE, cs_n=1, sclk=0, mosi=0, pres_en=0, busy=0, done=0, rx_data=0, shift registers=0, bit counter=0, pres_d=0.
REQ-031 After rst release, first accepted start SHALL be in IDLE on the first clk edge with rst high.

Verification
REQ-032 DATA_W=8, miso looped to mosi, start pulse with tx_data=0xA5 -> mosi bit sequence 1,0,1,0,0,1,0,1; 8 sclk rising edges; done one cycle; rx_data=0xA5.
REQ-033 miso tied 1, tx_data=0x00 -> rx_data=0xFF, mosi=0 throughout cs_n low window.
REQ-034 start held high across a full transfer -> second transfer begins only in the IDLE cycle after DONE; no data reload during transfer.
REQ-035 rst asserted after 3 sclk rising edges -> same-cycle cs_n=1, sclk=0, pres_en=0, busy=0, rx_data=0; no done pulse.
REQ-036 Check cs_n falls at least half an SCLK period before first sclk rise and rises one HOLD cycle plus one clk after last sclk fall; busy high from cycle after start through DONE.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master transfer controller.
// Shifts DATA_W bits MSB first on mosi and captures miso, using an external
// prescaler clock (pres_clk) whose edges are detected against a one-cycle
// delayed copy. sclk is that same clock re-registered, so mosi, which changes
// on the pres_clk fall, leads every sclk rise by half an SCLK period.
module spi_xfer_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              pres_clk,
  output logic              pres_en,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);

  // Counter must reach DATA_W itself, hence the extra bit.
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              pres_d_q, pres_d_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              pres_en_q, pres_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rise, fall;

  assign rise = pres_clk & ~pres_d_q;
  assign fall = ~pres_clk & pres_d_q;

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    pres_d_d   = pres_clk;
    sclk_d     = 1'b0;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    pres_en_d  = pres_en_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Edge detector is parked so a stale high cannot fake a fall later.
        pres_d_d = 1'b0;
        if (start) begin
          tx_shift_d = tx_data;
          mosi_d     = tx_data[DATA_W-1];
          cs_n_d     = 1'b0;
          pres_en_d  = 1'b1;
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        sclk_d = pres_clk;
        if (rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end else if (fall) begin
          if (bit_cnt_q == CNT_W'(DATA_W)) begin
            // Last falling edge: stop the prescaler, keep mosi as-is.
            pres_en_d = 1'b0;
            sclk_d    = 1'b0;
            state_d   = HOLD;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            mosi_d     = tx_shift_q[DATA_W-2];
          end
        end
      end
      HOLD: begin
        // One quiet cycle with cs_n still low before releasing the slave.
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        cs_n_d    = 1'b1;
        rx_data_d = rx_shift_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops everything back to IDLE at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      pres_d_q   <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      pres_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      pres_d_q   <= pres_d_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      pres_en_q  <= pres_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pres_en = pres_en_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
